// File: rtl/aq_ifu_ipack_rd.sv
// Read side of the IFU instruction package buffer: assembles RVC/32-bit instructions
// from half-word entries and issues them through a registered valid/ready stage.
// Optional feature: define AQ_IFU_IPACK_EXPT_EARLY_EN to issue a faulting half0 on its own.
module aq_ifu_ipack_rd #(
    parameter int unsigned ENTRY_NUM = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   ipack_buf_flush,
    input  logic [ENTRY_NUM-1:0]   ipack_entry_vld,
    input  logic [16*ENTRY_NUM-1:0] ipack_entry_inst,
    input  logic [ENTRY_NUM-1:0]   ipack_entry_acc_err,
    input  logic [ENTRY_NUM-1:0]   ipack_entry_pgflt,
    output logic [ENTRY_NUM-1:0]   ipack_entry_retire_en,
    output logic [PTR_W-1:0]       ipack_rd_ptr,
    output logic                   ifu_idu_inst_vld,
    output logic [31:0]            ifu_idu_inst,
    output logic                   ifu_idu_inst_is16,
    output logic                   ifu_idu_acc_err,
    output logic                   ifu_idu_pgflt,
    output logic                   ifu_idu_expt_hi,
    input  logic                   idu_ifu_inst_ready
);

    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
    logic             vld_q, vld_d;
    logic [31:0]      inst_q, inst_d;
    logic             is16_q, is16_d;
    logic             acc_q, acc_d;
    logic             pg_q, pg_d;
    logic             hi_q, hi_d;

    logic [15:0]      h0, h1;
    logic             vld0, vld1, acc0, acc1, pg0, pg1, fault0, fault1;
    logic             is16, single, cand_rdy, load;
    logic [ENTRY_NUM-1:0] oh0, oh1;

    always_comb begin
        ptr_nxt = ptr_q + PTR_W'(1);
        h0      = ipack_entry_inst[{ptr_q, 4'b0000} +: 16];
        h1      = ipack_entry_inst[{ptr_nxt, 4'b0000} +: 16];
        vld0    = ipack_entry_vld[ptr_q];
        vld1    = ipack_entry_vld[ptr_nxt];
        acc0    = ipack_entry_acc_err[ptr_q];
        acc1    = ipack_entry_acc_err[ptr_nxt];
        pg0     = ipack_entry_pgflt[ptr_q];
        pg1     = ipack_entry_pgflt[ptr_nxt];
        fault0  = acc0 | pg0;
        fault1  = acc1 | pg1;
        is16    = (h0[1:0] != 2'b11);
`ifdef AQ_IFU_IPACK_EXPT_EARLY_EN
        // A faulting half0 is issued alone; its upper half is never needed.
        single  = is16 | fault0;
`else
        single  = is16;
`endif
        cand_rdy = vld0 & (single | vld1);
        load     = cand_rdy & (~vld_q | idu_ifu_inst_ready) & ~ipack_buf_flush;
        oh0      = ENTRY_NUM'(1) << ptr_q;
        oh1      = ENTRY_NUM'(1) << ptr_nxt;
    end

    always_comb begin
        ipack_entry_retire_en = '0;
        if (load && cpurst_b) begin
            ipack_entry_retire_en = single ? oh0 : (oh0 | oh1);
        end
    end

    always_comb begin
        vld_d  = vld_q;
        inst_d = inst_q;
        is16_d = is16_q;
        acc_d  = acc_q;
        pg_d   = pg_q;
        hi_d   = hi_q;
        ptr_d  = ptr_q;
        if (ipack_buf_flush) begin
            vld_d = 1'b0;
            ptr_d = '0;
        end else if (load) begin
            vld_d  = 1'b1;
            inst_d = single ? {16'b0, h0} : {h1, h0};
            is16_d = is16;
            acc_d  = acc0 | (~single & acc1);
            pg_d   = pg0 | (~single & pg1);
            hi_d   = ~single & ~fault0 & fault1;
            ptr_d  = single ? ptr_nxt : (ptr_q + PTR_W'(2));
        end else if (idu_ifu_inst_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            vld_q  <= 1'b0;
            inst_q <= '0;
            is16_q <= 1'b0;
            acc_q  <= 1'b0;
            pg_q   <= 1'b0;
            hi_q   <= 1'b0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            inst_q <= inst_d;
            is16_q <= is16_d;
            acc_q  <= acc_d;
            pg_q   <= pg_d;
            hi_q   <= hi_d;
            ptr_q  <= ptr_d;
        end
    end

    assign ipack_rd_ptr      = ptr_q;
    assign ifu_idu_inst_vld  = vld_q;
    assign ifu_idu_inst      = inst_q;
    assign ifu_idu_inst_is16 = is16_q;
    assign ifu_idu_acc_err   = acc_q;
    assign ifu_idu_pgflt     = pg_q;
    assign ifu_idu_expt_hi   = hi_q;

endmodule

// File: tb/tb_aq_ifu_ipack_rd.sv
// Self-checking bench for aq_ifu_ipack_rd: directed scenarios plus a randomized run
// against a transaction-level reference model of the package buffer reader.
module tb_aq_ifu_ipack_rd;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          ready;
    logic [N-1:0]  bvld;
    logic [15:0]   binst [N];
    logic [N-1:0]  bacc;
    logic [N-1:0]  bpg;
    logic [16*N-1:0] inst_bus;

    logic [N-1:0]  retire;
    logic [1:0]    rd_ptr;
    logic          o_vld, o_is16, o_acc, o_pg, o_hi;
    logic [31:0]   o_inst;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        inst_bus = '0;
        for (int i = 0; i < N; i++) inst_bus[16*i +: 16] = binst[i];
    end

    aq_ifu_ipack_rd #(.ENTRY_NUM(N), .PTR_W(2)) dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_n),
        .ipack_buf_flush       (flush),
        .ipack_entry_vld       (bvld),
        .ipack_entry_inst      (inst_bus),
        .ipack_entry_acc_err   (bacc),
        .ipack_entry_pgflt     (bpg),
        .ipack_entry_retire_en (retire),
        .ipack_rd_ptr          (rd_ptr),
        .ifu_idu_inst_vld      (o_vld),
        .ifu_idu_inst          (o_inst),
        .ifu_idu_inst_is16     (o_is16),
        .ifu_idu_acc_err       (o_acc),
        .ifu_idu_pgflt         (o_pg),
        .ifu_idu_expt_hi       (o_hi),
        .idu_ifu_inst_ready    (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) binst[i] = 16'h0001;
        bvld = '1; bacc = '0; bpg = '0; ready = 1'b1; flush = 1'b0;
        rst_n = 1'b0;
        tick();
        #1;
        tests_run++;
        if (retire !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_retire: got %b expected 0000", retire);
        end
        tick();
        tests_run++;
        if (o_vld !== 1'b0 || o_inst !== 32'h0 || rd_ptr !== 2'd0 || retire !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: got vld=%b inst=%h ptr=%0d ret=%b expected 0/0/0/0",
                     o_vld, o_inst, rd_ptr, retire);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mixed();
        logic [3:0]  exp_ret [3];
        logic [31:0] exp_inst [3];
        logic        exp_is16 [3];
        logic [1:0]  exp_ptr [3];
        exp_ret  = '{4'b0001, 4'b0110, 4'b1000};
        exp_inst = '{32'h0000_4501, 32'h0000_0513, 32'h0000_8082};
        exp_is16 = '{1'b1, 1'b0, 1'b1};
        exp_ptr  = '{2'd1, 2'd3, 2'd0};
        do_reset();
        binst[0] = 16'h4501; binst[1] = 16'h0513; binst[2] = 16'h0000; binst[3] = 16'h8082;
        bvld = 4'b1111; bacc = '0; bpg = '0; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (retire !== exp_ret[k]) begin
                tests_failed++;
                $display("FAIL mixed_retire%0d: got %b expected %b", k, retire, exp_ret[k]);
            end
            tick();
            bvld = bvld & ~exp_ret[k];
            tests_run++;
            if (o_vld !== 1'b1 || o_inst !== exp_inst[k] || o_is16 !== exp_is16[k] ||
                rd_ptr !== exp_ptr[k]) begin
                tests_failed++;
                $display("FAIL mixed_issue%0d: got vld=%b inst=%h is16=%b ptr=%0d expected 1/%h/%b/%0d",
                         k, o_vld, o_inst, o_is16, rd_ptr, exp_inst[k], exp_is16[k], exp_ptr[k]);
            end
        end
        tick();
        tests_run++;
        if (o_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL mixed_drain: got vld=%b expected 0", o_vld);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        binst[0] = 16'h0001; binst[1] = 16'h0005; binst[2] = 16'h0009; binst[3] = 16'h000d;
        bvld = 4'b1111; bacc = '0; bpg = '0; ready = 1'b0;
        tick();
        bvld = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (retire !== 4'b0000 || rd_ptr !== 2'd1 || o_vld !== 1'b1 ||
                o_inst !== 32'h0000_0001) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got ret=%b ptr=%0d vld=%b inst=%h expected 0000/1/1/00000001",
                         k, retire, rd_ptr, o_vld, o_inst);
            end
            tick();
        end
        ready = 1'b1;
        #1;
        tests_run++;
        if (retire !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_resume_retire: got %b expected 0010", retire);
        end
        tick();
        bvld = 4'b1100;
        tests_run++;
        if (o_inst !== 32'h0000_0005 || rd_ptr !== 2'd2 || o_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_resume_issue: got inst=%h ptr=%0d vld=%b expected 00000005/2/1",
                     o_inst, rd_ptr, o_vld);
        end
        bvld = '0;
    endtask

    task automatic test_wrap_stall();
        do_reset();
        binst[0] = 16'h0001; binst[1] = 16'h0001; binst[2] = 16'h0001; binst[3] = 16'h0000;
        bvld = 4'b0111; bacc = '0; bpg = '0; ready = 1'b1;
        tick(); bvld = 4'b0110;
        tick(); bvld = 4'b0100;
        tick(); bvld = 4'b0000;
        binst[3] = 16'h0093;
        bvld = 4'b1000;
        #1;
        tests_run++;
        if (retire !== 4'b0000) begin
            tests_failed++;
            $display("FAIL wrap_stall_retire: got %b expected 0000", retire);
        end
        tick();
        tests_run++;
        if (o_vld !== 1'b0 || rd_ptr !== 2'd3) begin
            tests_failed++;
            $display("FAIL wrap_stall_state: got vld=%b ptr=%0d expected 0/3", o_vld, rd_ptr);
        end
        binst[0] = 16'h0010;
        bvld = 4'b1001;
        #1;
        tests_run++;
        if (retire !== 4'b1001) begin
            tests_failed++;
            $display("FAIL wrap_retire: got %b expected 1001", retire);
        end
        tick();
        bvld = '0;
        tests_run++;
        if (o_vld !== 1'b1 || o_inst !== 32'h0010_0093 || o_is16 !== 1'b0 || rd_ptr !== 2'd1) begin
            tests_failed++;
            $display("FAIL wrap_issue: got vld=%b inst=%h is16=%b ptr=%0d expected 1/00100093/0/1",
                     o_vld, o_inst, o_is16, rd_ptr);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < N; i++) binst[i] = 16'h0001;
        bvld = 4'b1111; bacc = '0; bpg = '0; ready = 1'b0;
        tick();
        bvld = 4'b1110;
        flush = 1'b1;
        #1;
        tests_run++;
        if (retire !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flush_retire: got %b expected 0000", retire);
        end
        tick();
        flush = 1'b0;
        bvld = '0;
        tests_run++;
        if (o_vld !== 1'b0 || rd_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_state: got vld=%b ptr=%0d expected 0/0", o_vld, rd_ptr);
        end
    endtask

    task automatic test_fault();
        do_reset();
        binst[0] = 16'h0297; binst[1] = 16'h0000;
        bvld = 4'b0001; bacc = '0; bpg = 4'b0001; ready = 1'b1;
        #1;
        tests_run++;
`ifdef AQ_IFU_IPACK_EXPT_EARLY_EN
        if (retire !== 4'b0001) begin
            tests_failed++;
            $display("FAIL fault_early_retire: got %b expected 0001", retire);
        end
        tick();
        tests_run++;
        if (o_vld !== 1'b1 || o_inst !== 32'h0000_0297 || o_is16 !== 1'b0 || o_pg !== 1'b1 ||
            o_hi !== 1'b0 || rd_ptr !== 2'd1) begin
            tests_failed++;
            $display("FAIL fault_early_issue: got vld=%b inst=%h is16=%b pg=%b hi=%b ptr=%0d",
                     o_vld, o_inst, o_is16, o_pg, o_hi, rd_ptr);
        end
`else
        if (retire !== 4'b0000) begin
            tests_failed++;
            $display("FAIL fault_stall_retire: got %b expected 0000", retire);
        end
        tick();
        tests_run++;
        if (o_vld !== 1'b0 || rd_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL fault_stall_state: got vld=%b ptr=%0d expected 0/0", o_vld, rd_ptr);
        end
`endif
        do_reset();
        binst[0] = 16'h0297; binst[1] = 16'h0000;
        bvld = 4'b0011; bacc = 4'b0010; bpg = '0; ready = 1'b1;
        #1;
        tests_run++;
        if (retire !== 4'b0011) begin
            tests_failed++;
            $display("FAIL fault_hi_retire: got %b expected 0011", retire);
        end
        tick();
        bvld = '0; bacc = '0;
        tests_run++;
        if (o_inst !== 32'h0000_0297 || o_acc !== 1'b1 || o_pg !== 1'b0 || o_hi !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_hi_issue: got inst=%h acc=%b pg=%b hi=%b expected 00000297/1/0/1",
                     o_inst, o_acc, o_pg, o_hi);
        end
    endtask

    // Reference: the bench acts as buffer writer and tracks the issue register abstractly.
    task automatic test_random();
        int          mp;
        bit          mv, m16, macc, mpg, mhi;
        logic [31:0] minst;
        int          p1, step;
        bit          c16, early, rdy, ld;
        logic [15:0] h0;
        logic [3:0]  eret;
        do_reset();
        bvld = '0; bacc = '0; bpg = '0;
        mp = 0; mv = 0; m16 = 0; macc = 0; mpg = 0; mhi = 0; minst = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bvld[i] && $urandom_range(0, 2) != 0) begin
                    binst[i] = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) binst[i][1:0] = 2'b11;
                    bacc[i] = ($urandom_range(0, 9) == 0);
                    bpg[i]  = ($urandom_range(0, 9) == 0);
                    bvld[i] = 1'b1;
                end
            end
            ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 29) == 0);
            h0    = binst[mp];
            p1    = (mp + 1) % N;
            c16   = (h0[1:0] != 2'b11);
`ifdef AQ_IFU_IPACK_EXPT_EARLY_EN
            early = !c16 && (bacc[mp] || bpg[mp]);
`else
            early = 1'b0;
`endif
            rdy   = bvld[mp] && (c16 || early || bvld[p1]);
            ld    = rdy && (!mv || ready) && !flush;
            eret  = '0;
            if (ld) begin
                eret[mp] = 1'b1;
                if (!c16 && !early) eret[p1] = 1'b1;
            end
            #1;
            tests_run++;
            if (retire !== eret || rd_ptr !== 2'(mp) || o_vld !== mv) begin
                tests_failed++;
                $display("FAIL rand_ctrl c%0d: got ret=%b ptr=%0d vld=%b expected %b/%0d/%b",
                         c, retire, rd_ptr, o_vld, eret, mp, mv);
            end
            if (mv) begin
                tests_run++;
                if (o_inst !== minst || o_is16 !== m16 || o_acc !== macc || o_pg !== mpg ||
                    o_hi !== mhi) begin
                    tests_failed++;
                    $display("FAIL rand_data c%0d: got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
                             c, o_inst, o_is16, o_acc, o_pg, o_hi, minst, m16, macc, mpg, mhi);
                end
            end
            if (flush) begin
                mv = 0;
                mp = 0;
            end else if (ld) begin
                step  = (c16 || early) ? 1 : 2;
                mv    = 1;
                m16   = c16;
                minst = (step == 1) ? {16'h0, h0} : {binst[p1], h0};
                macc  = bacc[mp] || (step == 2 && bacc[p1]);
                mpg   = bpg[mp] || (step == 2 && bpg[p1]);
                mhi   = (step == 2) && !(bacc[mp] || bpg[mp]) && (bacc[p1] || bpg[p1]);
                mp    = (mp + step) % N;
            end else if (ready) begin
                mv = 0;
            end
            tick();
            bvld = bvld & ~eret;
            if (flush) bvld = '0;
        end
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
        bvld = '0; bacc = '0; bpg = '0;
        for (int i = 0; i < N; i++) binst[i] = '0;
        tick();
        test_reset();
        test_mixed();
        test_backpressure();
        test_wrap_stall();
        test_flush();
        test_fault();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
